// File: rtl/miner_pkg.sv
// Shared types and defaults for the miner search controller and nonce counter.
package miner_pkg;

    localparam int DEF_NONCE_W = 32;
    localparam int DEF_HASH_W  = 256;
    localparam int CORES       = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        ISSUE     = 3'd2,
        WAIT      = 3'd3,
        COMPARE   = 3'd4,
        FOUND     = 3'd5,
        EXHAUSTED = 3'd6
    } dispatch_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            sat_inc32 = v;
        end else begin
            sat_inc32 = v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/miner_dispatch_ctrl_if.sv
// Valid/ready request and done/result return path between the dispatch controller and the hash core.
interface miner_dispatch_ctrl_if #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256
);
    logic               hash_valid;
    logic               hash_ready;
    logic [NONCE_W-1:0] hash_nonce;
    logic               hash_done;
    logic [HASH_W-1:0]  hash_result;

    modport master (
        output hash_valid, hash_nonce,
        input  hash_ready, hash_done, hash_result
    );

    modport slave (
        input  hash_valid, hash_nonce,
        output hash_ready, hash_done, hash_result
    );
endinterface

// File: rtl/miner_target_cmp.sv
// Registered unsigned less-than of a hash result against the target (1-cycle latency).
module miner_target_cmp #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);
    logic lt_r;

    // Capture the comparison only when a fresh result arrives
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lt_r <= 1'b0;
        end else if (en) begin
            lt_r <= (a < b);
        end else begin
            lt_r <= lt_r;
        end
    end

    assign lt = lt_r;
endmodule

// File: rtl/miner_dispatch_ctrl.sv
// Nonce search controller: clears/steps the counter, issues nonces to the hash core, checks against target.
// Optional hash-core watchdog enabled by defining MINER_HASH_TIMEOUT_EN.
module miner_dispatch_ctrl
    import miner_pkg::*;
#(
    parameter int NONCE_W        = DEF_NONCE_W,
    parameter int HASH_W         = DEF_HASH_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [HASH_W-1:0]     target,
    output logic                  cnt_clear,
    output logic                  cnt_enable,
    input  logic [NONCE_W-1:0]    nonce,
    input  logic                  nonce_flag,
    miner_dispatch_ctrl_if.master hif,
    output logic                  busy,
    output logic                  found,
    output logic [NONCE_W-1:0]    golden_nonce,
    output logic                  exhausted,
    output logic [31:0]           hash_count
);
    dispatch_state_t     state_r, next_state_s;
    logic [HASH_W-1:0]   target_r;
    logic [NONCE_W-1:0]  hash_nonce_r, golden_nonce_r;
    logic                found_r, exhausted_r, hit_s, start_ok_s;
    logic [31:0]         hash_count_r;
    logic                cnt_clear_s, cnt_enable_s, hash_valid_s, busy_s;

    assign start_ok_s = start && ((state_r == IDLE) || (state_r == FOUND) || (state_r == EXHAUSTED));

    miner_target_cmp #(.W(HASH_W)) u_cmp (
        .clk   (clk),
        .n_rst (n_rst),
        .en    ((state_r == WAIT) && hif.hash_done),
        .a     (hif.hash_result),
        .b     (target_r),
        .lt    (hit_s)
    );

`ifdef MINER_HASH_TIMEOUT_EN
    logic [31:0] wd_cnt_r;
    logic        wd_expired_s;

    assign wd_expired_s = (wd_cnt_r == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog counts consecutive WAIT cycles
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt_r <= 32'd0;
        end else if (state_r == WAIT) begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
        end else begin
            wd_cnt_r <= 32'd0;
        end
    end
`else
    logic wd_expired_s;
    logic unused_timeout_s;

    assign wd_expired_s     = 1'b0;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides every other event
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, FOUND, EXHAUSTED: next_state_s = start ? CLEAR : state_r;
                CLEAR:   next_state_s = ISSUE;
                ISSUE:   next_state_s = hif.hash_ready ? WAIT : ISSUE;
                WAIT: begin
                    if (hif.hash_done) begin
                        next_state_s = COMPARE;
                    end else if (wd_expired_s) begin
                        next_state_s = ISSUE;
                    end else begin
                        next_state_s = WAIT;
                    end
                end
                COMPARE: begin
                    if (hit_s) begin
                        next_state_s = FOUND;
                    end else if (nonce_flag) begin
                        next_state_s = EXHAUSTED;
                    end else begin
                        next_state_s = ISSUE;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        cnt_clear_s  = 1'b0;
        cnt_enable_s = 1'b0;
        hash_valid_s = 1'b0;
        busy_s       = 1'b1;
        case (state_r)
            IDLE, FOUND, EXHAUSTED: busy_s = 1'b0;
            CLEAR:   cnt_clear_s  = 1'b1;
            ISSUE:   hash_valid_s = 1'b1;
            WAIT:    busy_s       = 1'b1;
            COMPARE: cnt_enable_s = !hit_s && !nonce_flag;
            default: busy_s       = 1'b0;
        endcase
    end

    // Search results, target latch and the nonce copy under hash
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            target_r       <= {HASH_W{1'b0}};
            hash_nonce_r   <= {NONCE_W{1'b0}};
            golden_nonce_r <= {NONCE_W{1'b0}};
            found_r        <= 1'b0;
            exhausted_r    <= 1'b0;
            hash_count_r   <= 32'd0;
        end else if (abort) begin
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
        end else if (start_ok_s) begin
            target_r       <= target;
            golden_nonce_r <= {NONCE_W{1'b0}};
            found_r        <= 1'b0;
            exhausted_r    <= 1'b0;
            hash_count_r   <= 32'd0;
        end else if (state_r == ISSUE) begin
            hash_nonce_r <= nonce;
        end else if (state_r == COMPARE) begin
            hash_count_r <= sat_inc32(hash_count_r);
            if (hit_s) begin
                found_r        <= 1'b1;
                golden_nonce_r <= hash_nonce_r;
            end else if (nonce_flag) begin
                exhausted_r <= 1'b1;
            end else begin
                found_r <= 1'b0;
            end
        end else begin
            hash_count_r <= hash_count_r;
        end
    end

    // The counter is frozen during ISSUE, so its live value is the nonce on offer
    assign hif.hash_nonce = (state_r == ISSUE) ? nonce : hash_nonce_r;
    assign hif.hash_valid = hash_valid_s;
    assign cnt_clear      = cnt_clear_s;
    assign cnt_enable     = cnt_enable_s;
    assign busy           = busy_s;
    assign found          = found_r;
    assign exhausted      = exhausted_r;
    assign golden_nonce   = golden_nonce_r;
    assign hash_count     = hash_count_r;
endmodule

// File: tb/tb_miner_dispatch_ctrl.sv
// Directed bench for miner_dispatch_ctrl with a behavioural nonce counter and hand-driven hash core.
module tb_miner_dispatch_ctrl;
    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [255:0] target = 256'd0;
    logic         cnt_clear, cnt_enable, busy, found, exhausted;
    logic [31:0]  nonce, golden_nonce, hash_count;
    logic [31:0]  flag_at = 32'd100;
    logic         nonce_flag;
    int           vec_cnt = 0;
    int           err_cnt = 0;

    miner_dispatch_ctrl_if #(.NONCE_W(32), .HASH_W(256)) hif ();

    miner_dispatch_ctrl #(.NONCE_W(32), .HASH_W(256), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .target       (target),
        .cnt_clear    (cnt_clear),
        .cnt_enable   (cnt_enable),
        .nonce        (nonce),
        .nonce_flag   (nonce_flag),
        .hif          (hif),
        .busy         (busy),
        .found        (found),
        .golden_nonce (golden_nonce),
        .exhausted    (exhausted),
        .hash_count   (hash_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)          nonce <= 32'd0;
        else if (cnt_clear)  nonce <= 32'd0;
        else if (cnt_enable) nonce <= nonce + 32'd1;
    end
    assign nonce_flag = (nonce == flag_at);

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!hif.hash_valid && n < 20) begin
            tick();
            n++;
        end
        if (!hif.hash_valid) check_val("valid_timeout", 256'd0, 256'd1);
    endtask

    task automatic pulse_start(input logic [255:0] tgt);
        target = tgt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Handshake one nonce, return a result two cycles later; ends in COMPARE
    task automatic do_hash(input logic [255:0] res, input logic [31:0] exp_n, input string tag);
        wait_valid();
        check_val({tag, "_nonce"}, hif.hash_nonce, exp_n);
        hif.hash_ready = 1'b1;
        tick();
        hif.hash_ready = 1'b0;
        check_val({tag, "_valid_drop"}, hif.hash_valid, 256'd0);
        tick();
        hif.hash_done   = 1'b1;
        hif.hash_result = res;
        tick();
        hif.hash_done   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "bench timeout");
    end

    initial begin
        hif.hash_ready  = 1'b0;
        hif.hash_done   = 1'b0;
        hif.hash_result = 256'd0;
        #12;
        check_val("rst_busy", busy, 256'd0);
        check_val("rst_found", found, 256'd0);
        check_val("rst_exh", exhausted, 256'd0);
        check_val("rst_count", hash_count, 256'd0);
        check_val("rst_golden", golden_nonce, 256'd0);
        check_val("rst_valid", hif.hash_valid, 256'd0);
        check_val("rst_hnonce", hif.hash_nonce, 256'd0);
        check_val("rst_clr", cnt_clear, 256'd0);
        check_val("rst_en", cnt_enable, 256'd0);
        tick();
        n_rst = 1'b1;
        tick();
        check_val("idle_busy", busy, 256'd0);
        check_val("idle_clr", cnt_clear, 256'd0);

        // Test 1: start -> one clear cycle -> issue nonce 0
        pulse_start(256'h1);
        check_val("t1_clr_hi", cnt_clear, 256'd1);
        check_val("t1_busy", busy, 256'd1);
        tick();
        check_val("t1_clr_lo", cnt_clear, 256'd0);
        check_val("t1_valid", hif.hash_valid, 256'd1);
        check_val("t1_nonce0", hif.hash_nonce, 256'd0);

        // Test 2: result equal to target is a miss
        for (int i = 0; i < 3; i++) begin
            do_hash(256'h1, 32'(i), "t2");
            check_val("t2_cnt_en", cnt_enable, 256'd1);
            check_val("t2_clr", cnt_clear, 256'd0);
            tick();
        end
        check_val("t2_count", hash_count, 256'd3);
        check_val("t2_found", found, 256'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t2_abort_busy", busy, 256'd0);

        // Test 3: hit on third hash
        pulse_start({256{1'b1}});
        check_val("t3_count_clr", hash_count, 256'd0);
        tick();
        do_hash({256{1'b1}}, 32'd0, "t3a");
        tick();
        do_hash({256{1'b1}}, 32'd1, "t3b");
        tick();
        do_hash(256'd0, 32'd2, "t3c");
        check_val("t3_no_en_hit", cnt_enable, 256'd0);
        tick();
        check_val("t3_found", found, 256'd1);
        check_val("t3_golden", golden_nonce, 256'd2);
        check_val("t3_busy", busy, 256'd0);
        check_val("t3_count", hash_count, 256'd3);
        for (int i = 0; i < 4; i++) begin
            check_val("t3_en_quiet", cnt_enable, 256'd0);
            tick();
        end
        check_val("t3_found_held", found, 256'd1);

        // Test 4: counter flags nonce 4 as final, every result misses
        flag_at = 32'd4;
        pulse_start(256'h1);
        check_val("t4_found_clr", found, 256'd0);
        check_val("t4_golden_clr", golden_nonce, 256'd0);
        for (int i = 0; i < 5; i++) begin
            do_hash(256'h5, 32'(i), "t4");
            check_val("t4_cnt_en", cnt_enable, (i < 4) ? 256'd1 : 256'd0);
            tick();
        end
        check_val("t4_exh", exhausted, 256'd1);
        check_val("t4_found", found, 256'd0);
        check_val("t4_count", hash_count, 256'd5);
        check_val("t4_busy", busy, 256'd0);

        // Test 5: stalled ready, ignored start, abort colliding with a hit
        flag_at = 32'd100;
        pulse_start(256'h1);
        check_val("t5_exh_clr", exhausted, 256'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_val("t5_valid_hold", hif.hash_valid, 256'd1);
            check_val("t5_nonce_hold", hif.hash_nonce, 256'd0);
            start = (i == 5);
            tick();
            start = 1'b0;
        end
        check_val("t5_no_restart", cnt_clear, 256'd0);
        hif.hash_ready = 1'b1;
        tick();
        hif.hash_ready = 1'b0;
        tick();
        hif.hash_done   = 1'b1;
        hif.hash_result = 256'd0;
        abort           = 1'b1;
        tick();
        hif.hash_done = 1'b0;
        abort         = 1'b0;
        check_val("t5_busy", busy, 256'd0);
        check_val("t5_found", found, 256'd0);
        check_val("t5_valid", hif.hash_valid, 256'd0);
        check_val("t5_count", hash_count, 256'd0);
        tick();
        check_val("t5_idle_found", found, 256'd0);

`ifdef MINER_HASH_TIMEOUT_EN
        // Test 6: watchdog reissues the same nonce after 8 silent WAIT cycles
        pulse_start(256'h1);
        tick();
        hif.hash_ready = 1'b1;
        tick();
        hif.hash_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_val("t6_still_wait", hif.hash_valid, 256'd0);
        tick();
        check_val("t6_reissue", hif.hash_valid, 256'd1);
        check_val("t6_same_nonce", hif.hash_nonce, 256'd0);
        check_val("t6_count", hash_count, 256'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
